// File: rtl/debug_display_ctrl.sv
// Read-address controller for the debug display FIFO: write tracking, button debounce, browse stepping.
// Optional macro DEBUG_DISPLAY_AUTOSCAN_EN adds a periodic auto-scan up step.
module debug_display_ctrl #(
  parameter int DEPTH       = 32,
  parameter int AW          = 5,
  parameter int DB_CYCLES   = 50000,
  parameter int SCAN_PERIOD = 50000000
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          mmio_wea,
  input  logic          btn_up,
  input  logic          btn_dn,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] wr_ptr,
  output logic [AW:0]   wr_count,
  output logic          buf_full,
  output logic          up_pulse,
  output logic          dn_pulse
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ONE  = DBW'(1);
  localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);

  localparam logic [1:0] HELD = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] ARM  = 2'd2;
  localparam logic [1:0] REL  = 2'd3;

  if (DEPTH != (1 << AW) || DEPTH < 2 || DEPTH > 32 || DB_CYCLES < 2 || SCAN_PERIOD < 1) begin : g_param_check
    $error("debug_display_ctrl: illegal parameter set");
  end

  logic [1:0] btn_raw;
  logic [1:0] pulse_vec;
  assign btn_raw = {btn_dn, btn_up};

  // Reset lands in HELD so a button held through reset must be released before it can fire.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic           sync1_reg;
    logic           sync2_reg;
    logic [1:0]     state_reg;
    logic [DBW-1:0] cnt_reg;
    logic           pulse_reg;

    always_ff @(posedge clk) begin
      if (Rst) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        state_reg <= HELD;
        cnt_reg   <= '0;
        pulse_reg <= 1'b0;
      end else begin
        sync1_reg <= btn_raw[gi];
        sync2_reg <= sync1_reg;
        pulse_reg <= 1'b0;
        case (state_reg)
          IDLE: begin
            if (sync2_reg) begin
              state_reg <= ARM;
              cnt_reg   <= DB_ONE;
            end
          end
          ARM: begin
            if (!sync2_reg) begin
              state_reg <= IDLE;
            end else if (cnt_reg == DB_LAST) begin
              pulse_reg <= 1'b1;
              state_reg <= HELD;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          HELD: begin
            if (!sync2_reg) begin
              state_reg <= REL;
              cnt_reg   <= DB_ONE;
            end
          end
          default: begin
            if (sync2_reg) begin
              state_reg <= HELD;
            end else if (cnt_reg == DB_LAST) begin
              state_reg <= IDLE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        endcase
      end
    end

    assign pulse_vec[gi] = pulse_reg;
  end

  assign up_pulse = pulse_vec[0];
  assign dn_pulse = pulse_vec[1];

  logic step_up;
  logic step_dn;

`ifdef DEBUG_DISPLAY_AUTOSCAN_EN
  localparam int SW = $clog2(SCAN_PERIOD + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_PERIOD - 1);

  logic [SW-1:0] scan_cnt_reg;
  logic          scan_tick;
  assign scan_tick = (scan_cnt_reg == SCAN_LAST);

  // Any accepted press restarts the period so manual browsing is not overridden.
  always_ff @(posedge clk) begin
    if (Rst || up_pulse || dn_pulse || scan_tick) begin
      scan_cnt_reg <= '0;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  assign step_up = up_pulse ? ~dn_pulse : (scan_tick & ~dn_pulse);
`else
  assign step_up = up_pulse & ~dn_pulse;
`endif
  assign step_dn = dn_pulse & ~up_pulse;

  logic [AW:0]   count_next;
  logic [AW:0]   rd_ext;
  logic [AW:0]   rd_inc;
  logic [AW:0]   count_m1;
  logic [AW-1:0] rd_next;

  always_comb begin
    count_next = wr_count;
    if (mmio_wea && wr_count != DEPTH_W) begin
      count_next = wr_count + 1'b1;
    end
  end

  // Stepping wraps over valid entries only and sees the count from before any same-cycle write.
  always_comb begin
    rd_ext   = {1'b0, rd_addr};
    rd_inc   = rd_ext + 1'b1;
    count_m1 = wr_count - 1'b1;
    rd_next  = rd_addr;
    if (wr_count != '0) begin
      if (step_up) begin
        rd_next = (rd_inc >= wr_count) ? '0 : rd_inc[AW-1:0];
      end else if (step_dn) begin
        rd_next = (rd_addr == '0 || rd_ext >= wr_count) ? count_m1[AW-1:0] : rd_addr - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      rd_addr  <= '0;
      wr_ptr   <= '0;
      wr_count <= '0;
      buf_full <= 1'b0;
    end else begin
      rd_addr  <= rd_next;
      wr_count <= count_next;
      buf_full <= (count_next == DEPTH_W);
      if (mmio_wea) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_debug_display_ctrl.sv
// Randomized and directed bench for debug_display_ctrl against an in-bench behavioural model.
// Honours DEBUG_DISPLAY_AUTOSCAN_EN when defined for the build.
module tb_debug_display_ctrl;

  localparam int DEPTH       = 32;
  localparam int AW          = 5;
  localparam int DB_CYCLES   = 4;
  localparam int SCAN_PERIOD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mmio_wea = 1'b0;
  logic          btn_up = 1'b0;
  logic          btn_dn = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   wr_count;
  logic          buf_full;
  logic          up_pulse;
  logic          dn_pulse;

  debug_display_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .DB_CYCLES(DB_CYCLES), .SCAN_PERIOD(SCAN_PERIOD)
  ) dut (
    .clk(clk), .Rst(rst), .mmio_wea(mmio_wea), .btn_up(btn_up), .btn_dn(btn_dn),
    .rd_addr(rd_addr), .wr_ptr(wr_ptr), .wr_count(wr_count), .buf_full(buf_full),
    .up_pulse(up_pulse), .dn_pulse(dn_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int up_seen  = 0;
  int dn_seen  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: a button is "accepted" at a level once its synchronized input has
  // disagreed with the accepted level for DB_CYCLES consecutive samples; reset treats it as pressed.
  int m_rd = 0, m_count = 0, m_ptr = 0, m_since = 0;
  bit m_pulse[2];
  bit acc[2];
  int run[2];
  bit dl[2][2];

  always @(posedge clk) begin : model
    bit raw[2];
    bit syn;
    bit tick;
    bit su, sd;
    raw[0] = btn_up;
    raw[1] = btn_dn;
    if (rst) begin
      m_rd = 0; m_count = 0; m_ptr = 0; m_since = 0;
      for (int b = 0; b < 2; b++) begin
        m_pulse[b] = 0; acc[b] = 1; run[b] = 0; dl[b][0] = 0; dl[b][1] = 0;
      end
    end else begin
      tick = 0;
`ifdef DEBUG_DISPLAY_AUTOSCAN_EN
      if (m_pulse[0] || m_pulse[1]) m_since = 0;
      else begin
        m_since++;
        if (m_since == SCAN_PERIOD) begin tick = 1; m_since = 0; end
      end
`endif
      su = (m_pulse[0] && !m_pulse[1]) || (tick && !m_pulse[0] && !m_pulse[1]);
      sd = m_pulse[1] && !m_pulse[0];
      if (m_count > 0) begin
        if (su) m_rd = (m_rd + 1 >= m_count) ? 0 : m_rd + 1;
        else if (sd) m_rd = (m_rd == 0 || m_rd >= m_count) ? m_count - 1 : m_rd - 1;
      end
      if (mmio_wea) begin
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_count < DEPTH) m_count++;
      end
      for (int b = 0; b < 2; b++) begin
        syn = dl[b][1];
        dl[b][1] = dl[b][0];
        dl[b][0] = raw[b];
        m_pulse[b] = 0;
        if (syn != acc[b]) begin
          run[b]++;
          if (run[b] == DB_CYCLES) begin
            acc[b] = syn; run[b] = 0; m_pulse[b] = syn;
          end
        end else begin
          run[b] = 0;
        end
      end
    end
  end

  // Drive one cycle of inputs, then compare every output at the following falling edge.
  task automatic cycle(input bit w, input bit u, input bit d);
    mmio_wea = w; btn_up = u; btn_dn = d;
    @(negedge clk);
    check("rd_addr", rd_addr, m_rd);
    check("wr_ptr", wr_ptr, m_ptr);
    check("wr_count", wr_count, m_count);
    check("buf_full", buf_full, (m_count == DEPTH));
    check("up_pulse", up_pulse, m_pulse[0]);
    check("dn_pulse", dn_pulse, m_pulse[1]);
    if (up_pulse === 1'b1) up_seen++;
    if (dn_pulse === 1'b1) dn_seen++;
  endtask

  task automatic hold(input bit w, input bit u, input bit d, input int n);
    repeat (n) cycle(w, u, d);
  endtask

  task automatic press(input bit u, input bit d);
    hold(0, u, d, 8);
    hold(0, 0, 0, 8);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    hold(0, 0, 0, n);
    rst = 1'b0;
  endtask

  initial begin : stim
    int lat;
    int len;
    bit u, d;
    @(negedge clk);

    do_reset(3);
    $display("reset applied for 3 cycles");
    check("reset_rd_addr", rd_addr, 0);
    check("reset_wr_count", wr_count, 0);

    hold(1, 0, 0, 5);
    hold(0, 0, 0, 6);
    $display("five writes issued");
    check("wr5_count", wr_count, 5);
    check("wr5_ptr", wr_ptr, 5);
    check("wr5_full", buf_full, 0);
`ifndef DEBUG_DISPLAY_AUTOSCAN_EN
    check("wr5_rd", rd_addr, 0);
    press(0, 1);
    $display("down press from 0");
    check("dn_wrap_rd", rd_addr, 4);
`endif

    up_seen = 0; lat = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(0, 1, 0);
      if (up_pulse === 1'b1 && lat == 0) lat = i;
    end
    hold(0, 0, 0, 8);
    $display("clean up press, latency %0d", lat);
    check("up_latency", lat, 6);
    check("up_width", up_seen, 1);
`ifndef DEBUG_DISPLAY_AUTOSCAN_EN
    check("up_wrap_rd", rd_addr, 0);
    press(0, 1);
    check("dn_again_rd", rd_addr, 4);
`endif

    do_reset(2);
    hold(1, 0, 0, 34);
    hold(0, 0, 0, 2);
    $display("34 writes issued");
    check("full_count", wr_count, 32);
    check("full_flag", buf_full, 1);
    check("full_ptr", wr_ptr, 2);
`ifndef DEBUG_DISPLAY_AUTOSCAN_EN
    press(0, 1);
    check("full_dn_rd", rd_addr, 31);
    press(1, 0);
    check("full_up_rd", rd_addr, 0);
`endif

    up_seen = 0;
    for (int i = 0; i < 10; i++) begin
      hold(0, 1, 0, 3);
      hold(0, 0, 0, 1 + (i % 3));
    end
    hold(0, 0, 0, 8);
    $display("bounce sequence applied");
    check("bounce_pulses", up_seen, 0);
`ifndef DEBUG_DISPLAY_AUTOSCAN_EN
    check("bounce_rd", rd_addr, 0);
`endif

    up_seen = 0;
    hold(0, 1, 0, 10000);
    hold(0, 0, 0, 8);
    $display("long hold of 10000 cycles");
    check("hold_pulses", up_seen, 1);

    do_reset(2);
    hold(1, 0, 0, 3);
    hold(0, 0, 0, 6);
    press(1, 0);
    press(1, 0);
    up_seen = 0; dn_seen = 0;
    press(1, 1);
    $display("simultaneous up and down press");
    check("both_up_seen", up_seen, 1);
    check("both_dn_seen", dn_seen, 1);
`ifndef DEBUG_DISPLAY_AUTOSCAN_EN
    check("both_rd", rd_addr, 2);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 0);
      if (up_pulse === 1'b1) begin
        cycle(1, 1, 0);
        break;
      end
    end
    hold(0, 0, 0, 8);
    $display("up pulse coincident with write");
    check("coinc_rd", rd_addr, 0);
    check("coinc_count", wr_count, 4);
`endif

    hold(0, 1, 0, 3);
    rst = 1'b1;
    hold(0, 1, 0, 2);
    rst = 1'b0;
    up_seen = 0;
    hold(0, 1, 0, 20);
    $display("reset during arm, button still held");
    check("rst_arm_pulses", up_seen, 0);
    check("rst_arm_rd", rd_addr, 0);
    check("rst_arm_count", wr_count, 0);
    hold(0, 0, 0, 8);
    press(1, 0);
    check("rearm_pulses", up_seen, 1);

`ifdef DEBUG_DISPLAY_AUTOSCAN_EN
    do_reset(2);
    hold(1, 0, 0, 3);
    hold(0, 0, 0, 40);
    $display("auto-scan idle run with three entries");
`endif

    for (int s = 0; s < 300; s++) begin
      len = $urandom_range(1, 10);
      u = $urandom_range(0, 1);
      d = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) rst = 1'b1;
      for (int j = 0; j < len; j++) cycle(($urandom_range(0, 3) == 0), u, d);
      rst = 1'b0;
      $display("segment %0d: up=%0b dn=%0b len=%0d rd=%0d count=%0d", s, u, d, len, m_rd, m_count);
    end
    hold(0, 0, 0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
